// File: rtl/adder4_resp_checker.sv
// ============================================================================
//  Module   : adder4_resp_checker
//  Purpose  : Scores a 4-bit adder's {cout,S} against A+B+cin and reports a run verdict.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder4_resp_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic             cin,
    input  logic [3:0]       S,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [8:0]       first_err_vec,
    output logic [4:0]       first_err_exp,
    output logic [4:0]       first_err_got
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         DRAIN_LEN    = (LATENCY == 0) ? 1 : LATENCY;
    localparam logic [1:0] c_drain_last = 2'(DRAIN_LEN - 1);

    state_t           state_q, state_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [8:0]       first_err_vec_q, first_err_vec_d;
    logic [4:0]       first_err_exp_q, first_err_exp_d;
    logic [4:0]       first_err_got_q, first_err_got_d;
    logic             mismatch_q, mismatch_d;

    logic       accept;
    logic       clear_run;
    logic [8:0] acc_vec;
    logic [4:0] acc_exp;
    logic       cmp_valid;
    logic [8:0] cmp_vec;
    logic [4:0] cmp_exp;
    logic [4:0] obs;
    logic       cmp_fail;

    assign accept    = (state_q == ST_RUN) && in_valid;
    assign clear_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign acc_vec   = {A, B, cin};
    assign acc_exp   = {1'b0, A} + {1'b0, B} + {4'b0000, cin};

    generate
        if (LATENCY == 0) begin : g_comb
            assign cmp_valid = accept;
            assign cmp_vec   = acc_vec;
            assign cmp_exp   = acc_exp;
        end else begin : g_pipe
            // Each stage carries {vector, expected}; only the valid bits need reset.
            logic [LATENCY-1:0] stg_valid_q, stg_valid_d;
            logic [13:0]        stg_data_q [LATENCY];
            logic [13:0]        stg_data_d [LATENCY];

            always_comb begin
                stg_valid_d    = stg_valid_q;
                stg_data_d     = stg_data_q;
                stg_valid_d[0] = accept;
                stg_data_d[0]  = {acc_vec, acc_exp};
                for (int i = 1; i < LATENCY; i++) begin
                    stg_valid_d[i] = stg_valid_q[i-1];
                    stg_data_d[i]  = stg_data_q[i-1];
                end
                if (clear_run) begin
                    stg_valid_d = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stg_valid_q <= '0;
                end else begin
                    stg_valid_q <= stg_valid_d;
                end
                stg_data_q <= stg_data_d;
            end

            assign cmp_valid = stg_valid_q[LATENCY-1];
            assign cmp_vec   = stg_data_q[LATENCY-1][13:5];
            assign cmp_exp   = stg_data_q[LATENCY-1][4:0];
        end
    endgenerate

    assign obs      = {cout, S};
    assign cmp_fail = cmp_valid && (obs != cmp_exp);

    always_comb begin
        state_d         = state_q;
        drain_cnt_d     = drain_cnt_q;
        vec_cnt_d       = vec_cnt_q;
        err_cnt_d       = err_cnt_q;
        first_err_vec_d = first_err_vec_q;
        first_err_exp_d = first_err_exp_q;
        first_err_got_d = first_err_got_q;
        mismatch_d      = cmp_fail;

        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (stop) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = c_drain_last;
                end
            end
            // Drain length equals the pipeline depth, so the last vector is scored on exit.
            ST_DRAIN: begin
                if (drain_cnt_q == 2'd0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end
            end
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        if (clear_run) begin
            vec_cnt_d       = '0;
            err_cnt_d       = '0;
            first_err_vec_d = '0;
            first_err_exp_d = '0;
            first_err_got_d = '0;
        end else if (cmp_valid) begin
            if (vec_cnt_q != '1) vec_cnt_d = vec_cnt_q + CNT_W'(1);
            if (cmp_fail) begin
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                if (err_cnt_q == '0) begin
                    first_err_vec_d = cmp_vec;
                    first_err_exp_d = cmp_exp;
                    first_err_got_d = obs;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            drain_cnt_q     <= 2'd0;
            vec_cnt_q       <= '0;
            err_cnt_q       <= '0;
            first_err_vec_q <= '0;
            first_err_exp_q <= '0;
            first_err_got_q <= '0;
            mismatch_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            drain_cnt_q     <= drain_cnt_d;
            vec_cnt_q       <= vec_cnt_d;
            err_cnt_q       <= err_cnt_d;
            first_err_vec_q <= first_err_vec_d;
            first_err_exp_q <= first_err_exp_d;
            first_err_got_q <= first_err_got_d;
            mismatch_q      <= mismatch_d;
        end
    end

    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_cnt_q == '0) && (vec_cnt_q != '0);
    assign mismatch      = mismatch_q;
    assign vec_cnt       = vec_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_vec = first_err_vec_q;
    assign first_err_exp = first_err_exp_q;
    assign first_err_got = first_err_got_q;

endmodule

`default_nettype wire

// File: tb/tb_adder4_resp_checker.sv
// ============================================================================
//  Module   : tb_adder4_resp_checker
//  Purpose  : Directed runs on three checker configurations, scored per run at done.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder4_resp_checker;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [4:0] e;
        logic [4:0] g;
    } vec_t;

    typedef struct {
        int         inst;
        int         vec;
        int         err;
        int         mm;
        logic       pass;
        logic [8:0] fvec;
        logic [4:0] fexp;
        logic [4:0] fgot;
    } exp_t;

    logic clk;
    logic [2:0]       rst_v, start_v, stop_v, inv_v, cin_v;
    logic [2:0][3:0]  a_v, b_v;
    logic [2:0][4:0]  got_v;
    logic [2:0][4:0]  rsp1, rsp2, rsp3;
    logic [2:0]       busy_v, done_v, pass_v, mm_v;
    logic [2:0][8:0]  fvec_v;
    logic [2:0][4:0]  fexp_v, fgot_v;
    logic [15:0]      vec0, err0, vec1, err1;
    logic [2:0]       vec2, err2;

    vec_t vq[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   mm_cnt[3] = '{0, 0, 0};
    bit   done_prev[3] = '{0, 0, 0};

    adder4_resp_checker #(.LATENCY(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .stop(stop_v[0]), .in_valid(inv_v[0]),
        .A(a_v[0]), .B(b_v[0]), .cin(cin_v[0]), .S(rsp1[0][3:0]), .cout(rsp1[0][4]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .mismatch(mm_v[0]),
        .vec_cnt(vec0), .err_cnt(err0), .first_err_vec(fvec_v[0]),
        .first_err_exp(fexp_v[0]), .first_err_got(fgot_v[0]));

    adder4_resp_checker #(.LATENCY(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .stop(stop_v[1]), .in_valid(inv_v[1]),
        .A(a_v[1]), .B(b_v[1]), .cin(cin_v[1]), .S(rsp3[1][3:0]), .cout(rsp3[1][4]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .mismatch(mm_v[1]),
        .vec_cnt(vec1), .err_cnt(err1), .first_err_vec(fvec_v[1]),
        .first_err_exp(fexp_v[1]), .first_err_got(fgot_v[1]));

    adder4_resp_checker #(.LATENCY(1), .CNT_W(3)) u_c3 (
        .clk(clk), .rst_n(rst_v[2]), .start(start_v[2]), .stop(stop_v[2]), .in_valid(inv_v[2]),
        .A(a_v[2]), .B(b_v[2]), .cin(cin_v[2]), .S(rsp1[2][3:0]), .cout(rsp1[2][4]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .mismatch(mm_v[2]),
        .vec_cnt(vec2), .err_cnt(err2), .first_err_vec(fvec_v[2]),
        .first_err_exp(fexp_v[2]), .first_err_got(fgot_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in adder: presents the scripted response LATENCY cycles after the vector.
    always @(posedge clk) begin
        rsp1 <= got_v;
        rsp2 <= rsp1;
        rsp3 <= rsp2;
    end

    function automatic logic [15:0] vec_of(input int k);
        case (k)
            0:       return vec0;
            1:       return vec1;
            default: return {13'd0, vec2};
        endcase
    endfunction

    function automatic logic [15:0] err_of(input int k);
        case (k)
            0:       return err0;
            1:       return err1;
            default: return {13'd0, err2};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Monitor: tallies mismatch pulses and scores each completed run against the scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mm_v[k] === 1'b1) mm_cnt[k]++;
            if (done_v[k] === 1'b1 && !done_prev[k]) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL u%0d unexpected done: got done with empty scoreboard, required none", k);
                end else begin
                    exp_t r;
                    r = sb.pop_front();
                    chk($sformatf("u%0d run owner", k), k, r.inst);
                    chk($sformatf("u%0d vec_cnt", k), {16'd0, vec_of(k)}, r.vec);
                    chk($sformatf("u%0d err_cnt", k), {16'd0, err_of(k)}, r.err);
                    chk($sformatf("u%0d pass", k), {31'd0, pass_v[k]}, {31'd0, r.pass});
                    chk($sformatf("u%0d first_err_vec", k), {23'd0, fvec_v[k]}, {23'd0, r.fvec});
                    chk($sformatf("u%0d first_err_exp", k), {27'd0, fexp_v[k]}, {27'd0, r.fexp});
                    chk($sformatf("u%0d first_err_got", k), {27'd0, fgot_v[k]}, {27'd0, r.fgot});
                    chk($sformatf("u%0d mismatch pulses", k), mm_cnt[k], r.mm);
                end
                mm_cnt[k] = 0;
            end
            done_prev[k] = (done_v[k] === 1'b1);
        end
    end

    task automatic add(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [4:0] e, input logic [4:0] g);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.e = e; v.g = g;
        vq.push_back(v);
    endtask

    task automatic check_idle(input int k);
        chk($sformatf("u%0d idle busy", k), {31'd0, busy_v[k]}, 0);
        chk($sformatf("u%0d idle done", k), {31'd0, done_v[k]}, 0);
        chk($sformatf("u%0d idle pass", k), {31'd0, pass_v[k]}, 0);
        chk($sformatf("u%0d idle mismatch", k), {31'd0, mm_v[k]}, 0);
        chk($sformatf("u%0d idle vec_cnt", k), {16'd0, vec_of(k)}, 0);
        chk($sformatf("u%0d idle err_cnt", k), {16'd0, err_of(k)}, 0);
        chk($sformatf("u%0d idle first_err_vec", k), {23'd0, fvec_v[k]}, 0);
        chk($sformatf("u%0d idle first_err_exp", k), {27'd0, fexp_v[k]}, 0);
        chk($sformatf("u%0d idle first_err_got", k), {27'd0, fgot_v[k]}, 0);
    endtask

    // Issues one run from vq on instance k (entered at a negedge) and times the drain.
    task automatic run(input int k, input bit stop_last);
        exp_t r;
        int   cmax, nerr, dcnt, n, nv, dlen;
        cmax = (k == 2) ? 7 : 65535;
        dlen = (k == 1) ? 3 : 1;
        nv   = vq.size();
        nerr = 0;
        r.inst = k; r.fvec = '0; r.fexp = '0; r.fgot = '0;
        for (int i = 0; i < nv; i++) begin
            if (vq[i].g != vq[i].e) begin
                if (nerr == 0) begin
                    r.fvec = {vq[i].a, vq[i].b, vq[i].c};
                    r.fexp = vq[i].e;
                    r.fgot = vq[i].g;
                end
                nerr++;
            end
        end
        r.vec  = (nv > cmax) ? cmax : nv;
        r.err  = (nerr > cmax) ? cmax : nerr;
        r.mm   = nerr;
        r.pass = (nerr == 0) && (nv > 0);
        sb.push_back(r);

        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        for (int i = 0; i < nv; i++) begin
            inv_v[k] = 1'b1;
            a_v[k] = vq[i].a; b_v[k] = vq[i].b; cin_v[k] = vq[i].c; got_v[k] = vq[i].g;
            stop_v[k] = stop_last && (i == nv - 1);
            @(negedge clk);
        end
        inv_v[k] = 1'b0; got_v[k] = '0;
        if (!stop_last) begin
            stop_v[k] = 1'b1;
            @(negedge clk);
        end
        stop_v[k] = 1'b0;
        dcnt = 0;
        n = 0;
        while (done_v[k] !== 1'b1 && n < 40) begin
            if (busy_v[k] === 1'b1) dcnt++;
            n++;
            @(negedge clk);
        end
        if (done_v[k] !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL u%0d done timeout: got no done after %0d cycles, required done", k, n);
        end else begin
            chk($sformatf("u%0d drain cycles", k), dcnt, dlen);
        end
        @(negedge clk);
        vq.delete();
    endtask

    initial begin
        rst_v = '0; start_v = '0; stop_v = '0; inv_v = '0; cin_v = '0;
        a_v = '0; b_v = '0; got_v = '0;
        repeat (3) @(negedge clk);
        rst_v = 3'b111;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_idle(k);

        // Clean run on LATENCY=1
        add(4'd0, 4'd0, 1'b0, 5'b00000, 5'b00000);
        add(4'd1, 4'd2, 1'b0, 5'b00011, 5'b00011);
        add(4'd5, 4'd3, 1'b1, 5'b01001, 5'b01001);
        add(4'd15, 4'd1, 1'b0, 5'b10000, 5'b10000);
        add(4'd15, 4'd15, 1'b1, 5'b11111, 5'b11111);
        run(0, 1'b0);

        // Single fault: S forced to zero for 1+2
        add(4'd3, 4'd4, 1'b0, 5'b00111, 5'b00111);
        add(4'd1, 4'd2, 1'b0, 5'b00011, 5'b00000);
        add(4'd8, 4'd8, 1'b0, 5'b10000, 5'b10000);
        run(0, 1'b0);

        // Two faults: first one must stick
        add(4'd10, 4'd5, 1'b0, 5'b01111, 5'b00000);
        add(4'd2, 4'd2, 1'b1, 5'b00101, 5'b00101);
        add(4'd9, 4'd6, 1'b1, 5'b10000, 5'b10001);
        run(0, 1'b0);

        // LATENCY=3 with stop on the last vector
        add(4'd7, 4'd8, 1'b0, 5'b01111, 5'b01111);
        add(4'd15, 4'd15, 1'b0, 5'b11110, 5'b11110);
        add(4'd6, 4'd6, 1'b1, 5'b01101, 5'b01101);
        run(1, 1'b1);
        add(4'd4, 4'd4, 1'b0, 5'b01000, 5'b01001);
        run(1, 1'b1);

        // CNT_W=3 saturation with nine clean vectors
        add(4'd0, 4'd0, 1'b0, 5'd0, 5'd0);
        add(4'd1, 4'd1, 1'b0, 5'd2, 5'd2);
        add(4'd2, 4'd2, 1'b0, 5'd4, 5'd4);
        add(4'd3, 4'd3, 1'b0, 5'd6, 5'd6);
        add(4'd4, 4'd4, 1'b0, 5'd8, 5'd8);
        add(4'd5, 4'd5, 1'b0, 5'd10, 5'd10);
        add(4'd6, 4'd6, 1'b0, 5'd12, 5'd12);
        add(4'd7, 4'd7, 1'b0, 5'd14, 5'd14);
        add(4'd8, 4'd8, 1'b0, 5'd16, 5'd16);
        run(2, 1'b0);

        // Reset mid-run overrides start/stop/in_valid, then a fresh run
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        inv_v[0] = 1'b1; a_v[0] = 4'd2; b_v[0] = 4'd3; cin_v[0] = 1'b0; got_v[0] = 5'b00101;
        @(negedge clk);
        a_v[0] = 4'd4; b_v[0] = 4'd5; cin_v[0] = 1'b1; got_v[0] = 5'b01010;
        @(negedge clk);
        a_v[0] = 4'd1; b_v[0] = 4'd1; cin_v[0] = 1'b0; got_v[0] = 5'b00010;
        rst_v[0] = 1'b0; start_v[0] = 1'b1; stop_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b1; start_v[0] = 1'b0; stop_v[0] = 1'b0; inv_v[0] = 1'b0; got_v[0] = '0;
        check_idle(0);
        @(negedge clk);
        chk("u0 post-reset still idle", {31'd0, busy_v[0]}, 0);
        add(4'd1, 4'd1, 1'b0, 5'b00010, 5'b00010);
        add(4'd6, 4'd7, 1'b0, 5'b01101, 5'b01101);
        add(4'd12, 4'd3, 1'b1, 5'b10000, 5'b10000);
        run(0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
